// File: rtl/rx_framer_pkg.sv
// Shared types and constants for the RX sample framer.
// Optional per-entry frame sequence field is enabled by RX_FRAMER_SEQ_EN.
package rx_framer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ERR  = 2'd2
    } state_e;

    localparam int unsigned REG_LEN = 0;
    localparam int unsigned REG_CMD = 1;
    localparam int unsigned REG_CLR = 2;

    localparam int unsigned CMD_START_BIT = 31;
    localparam int unsigned CMD_CONT_BIT  = 30;
    localparam int unsigned CMD_STOP_BIT  = 29;
    localparam int unsigned CMD_NUM_W     = 24;

    localparam int unsigned DATA_W      = 32;
    localparam int unsigned LEN_W       = 16;
    localparam int unsigned SEQ_W       = 12;
    localparam int unsigned ENTRY_W     = DATA_W + 3;
    localparam int unsigned ENTRY_SEQ_W = ENTRY_W + SEQ_W;

    localparam logic [DATA_W-1:0] TERM_DATA = '0;

    typedef struct packed {
        logic              err;
        logic              sof;
        logic              eof;
        logic [DATA_W-1:0] data;
    } entry_t;

    // Frame lengths 0 and 1 both mean one sample per frame.
    function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len);
        return (len == '0) ? LEN_W'(1) : len;
    endfunction

endpackage

// File: rtl/rx_framer_fifo.sv
// Synchronous show-ahead FIFO; head word is visible whenever not empty.
module rx_framer_fifo #(
    parameter int unsigned WIDTH = 35,
    parameter int unsigned AW    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      fill
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             push_c, pop_c;

    // A full FIFO refuses writes even when a read frees a slot this cycle.
    always_comb begin
        push_c   = wr_en && !full_q;
        pop_c    = rd_en && !empty_q;
        wr_ptr_d = push_c ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_c  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_c && !pop_c) begin
            cnt_d = cnt_q + (AW+1)'(1);
        end else if (!push_c && pop_c) begin
            cnt_d = cnt_q - (AW+1)'(1);
        end
        full_d  = (cnt_d == (AW+1)'(DEPTH));
        empty_d = (cnt_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // Storage is not cleared by reset, so the head is masked while empty.
    assign rd_data = empty_q ? '0 : mem_q[rd_ptr_q];
    assign full    = full_q;
    assign empty   = empty_q;
    assign fill    = cnt_q;

endmodule

// File: rtl/rx_sample_framer.sv
// Cuts the per-clock RX sample stream into framed valid/ready words with overflow handling.
// Define RX_FRAMER_SEQ_EN to add the per-word out_seq frame sequence number.
module rx_sample_framer
    import rx_framer_pkg::*;
#(
    parameter int unsigned BASE    = 176,
    parameter int unsigned FIFO_AW = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        set_stb,
    input  logic [7:0]  set_addr,
    input  logic [31:0] set_data,
    input  logic [31:0] sample,
    output logic [31:0] out_data,
    output logic        out_sof,
    output logic        out_eof,
    output logic        out_err,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        overflow,
`ifdef RX_FRAMER_SEQ_EN
    output logic [11:0] out_seq,
`endif
    output logic [31:0] status
);

`ifdef RX_FRAMER_SEQ_EN
    localparam int unsigned FIFO_W = ENTRY_SEQ_W;
`else
    localparam int unsigned FIFO_W = ENTRY_W;
`endif

    state_e                 state_q, state_d;
    logic [LEN_W-1:0]       frame_len_q, frame_len_d;
    logic [LEN_W-1:0]       len_q, len_d;
    logic [LEN_W-1:0]       pos_q, pos_d;
    logic [CMD_NUM_W-1:0]   remaining_q, remaining_d;
    logic                   cont_q, cont_d;
    logic                   stop_pend_q, stop_pend_d;
    logic                   overflow_q, overflow_d;
    logic [SEQ_W-1:0]       seq_q, seq_d;

    logic                   cmd_hit_c, len_hit_c, clr_hit_c;
    logic                   start_c, stop_c, ovf_set_c;
    logic [LEN_W-1:0]       cur_len_c;
    logic                   pos_eof_c, burst_last_c;
    logic                   wr_en_c;
    entry_t                 wr_entry_c, rd_entry_c;
    logic [FIFO_W-1:0]      wr_word_c, rd_word_c;
    logic                   fifo_full, fifo_empty;
    logic [FIFO_AW:0]       fifo_fill;
    logic                   unused_cmd_bits;

    assign unused_cmd_bits = &{1'b0, set_data[28:24]};

    // Settings decode; a stop in the same word overrides start.
    always_comb begin
        cmd_hit_c = set_stb && (set_addr == 8'(BASE + REG_CMD));
        len_hit_c = set_stb && (set_addr == 8'(BASE + REG_LEN));
        clr_hit_c = set_stb && (set_addr == 8'(BASE + REG_CLR));
        stop_c    = cmd_hit_c && set_data[CMD_STOP_BIT];
        start_c   = cmd_hit_c && set_data[CMD_START_BIT] && !set_data[CMD_STOP_BIT];
    end

    // The frame length is sampled at position 0 and held for the rest of the frame.
    always_comb begin
        cur_len_c    = (pos_q == '0) ? eff_len(frame_len_q) : len_q;
        pos_eof_c    = (pos_q == cur_len_c - LEN_W'(1));
        burst_last_c = !cont_q && (remaining_q == CMD_NUM_W'(1));
    end

    always_comb begin
        state_d     = state_q;
        frame_len_d = len_hit_c ? set_data[LEN_W-1:0] : frame_len_q;
        len_d       = len_q;
        pos_d       = pos_q;
        remaining_d = remaining_q;
        cont_d      = cont_q;
        stop_pend_d = 1'b0;
        seq_d       = seq_q;
        ovf_set_c   = 1'b0;
        wr_en_c     = 1'b0;
        wr_entry_c  = '0;

        case (state_q)
            IDLE: begin
                if (start_c && (set_data[CMD_CONT_BIT] || set_data[CMD_NUM_W-1:0] != '0)) begin
                    state_d     = RUN;
                    remaining_d = set_data[CMD_NUM_W-1:0];
                    cont_d      = set_data[CMD_CONT_BIT];
                    pos_d       = '0;
                    seq_d       = '0;
                end
            end
            RUN: begin
                if (fifo_full) begin
                    state_d   = ERR;
                    ovf_set_c = 1'b1;
                end else begin
                    wr_en_c         = 1'b1;
                    wr_entry_c.data = sample;
                    wr_entry_c.sof  = (pos_q == '0);
                    wr_entry_c.eof  = pos_eof_c || burst_last_c || stop_pend_q;
                    len_d           = cur_len_c;
                    pos_d           = wr_entry_c.eof ? '0 : pos_q + LEN_W'(1);
                    if (!cont_q) begin
                        remaining_d = remaining_q - CMD_NUM_W'(1);
                    end
                    if (burst_last_c || stop_pend_q) begin
                        state_d = IDLE;
                    end else begin
                        stop_pend_d = stop_c;
                    end
                end
            end
            ERR: begin
                if (!fifo_full) begin
                    wr_en_c         = 1'b1;
                    wr_entry_c.data = TERM_DATA;
                    wr_entry_c.err  = 1'b1;
                    wr_entry_c.sof  = (pos_q == '0);
                    wr_entry_c.eof  = 1'b1;
                    pos_d           = '0;
                    state_d         = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (wr_en_c && wr_entry_c.eof) begin
            seq_d = seq_q + SEQ_W'(1);
        end

        // A new overflow beats a clear in the same cycle.
        overflow_d = overflow_q;
        if (clr_hit_c) begin
            overflow_d = 1'b0;
        end
        if (ovf_set_c) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            frame_len_q <= '0;
            len_q       <= LEN_W'(1);
            pos_q       <= '0;
            remaining_q <= '0;
            cont_q      <= 1'b0;
            stop_pend_q <= 1'b0;
            overflow_q  <= 1'b0;
            seq_q       <= '0;
        end else begin
            state_q     <= state_d;
            frame_len_q <= frame_len_d;
            len_q       <= len_d;
            pos_q       <= pos_d;
            remaining_q <= remaining_d;
            cont_q      <= cont_d;
            stop_pend_q <= stop_pend_d;
            overflow_q  <= overflow_d;
            seq_q       <= seq_d;
        end
    end

`ifdef RX_FRAMER_SEQ_EN
    assign wr_word_c = {seq_q, wr_entry_c};
    assign out_seq   = rd_word_c[ENTRY_SEQ_W-1:ENTRY_W];
`else
    assign wr_word_c = wr_entry_c;
`endif

    rx_framer_fifo #(
        .WIDTH (FIFO_W),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en_c),
        .wr_data (wr_word_c),
        .rd_en   (out_ready),
        .rd_data (rd_word_c),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .fill    (fifo_fill)
    );

    assign rd_entry_c = entry_t'(rd_word_c[ENTRY_W-1:0]);
    assign out_data   = rd_entry_c.data;
    assign out_sof    = rd_entry_c.sof;
    assign out_eof    = rd_entry_c.eof;
    assign out_err    = rd_entry_c.err;
    assign out_valid  = !fifo_empty;
    assign overflow   = overflow_q;
    assign status     = {overflow_q, state_q, 21'd0, 8'(fifo_fill)};

endmodule

// File: tb/tb_rx_sample_framer.sv
// Scoreboard bench for rx_sample_framer (depth-4 FIFO build).
module tb_rx_sample_framer;

    localparam int unsigned B = 176;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        set_stb = 1'b0;
    logic [7:0]  set_addr = '0;
    logic [31:0] set_data = '0;
    logic [31:0] sample = '0;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_sof, out_eof, out_err, out_valid, overflow;
    logic [31:0] status;
`ifdef RX_FRAMER_SEQ_EN
    logic [11:0] out_seq;
`endif

    int          errors = 0;
    int          checks = 0;
    logic [34:0] exp_q[$];
    logic [34:0] exp_w;
    logic [34:0] obs_w;
    logic [31:0] ramp = 32'h1000_0000;

    assign obs_w = {out_err, out_sof, out_eof, out_data};

    always #5 clk = ~clk;

    rx_sample_framer #(.BASE(B), .FIFO_AW(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .set_stb   (set_stb),
        .set_addr  (set_addr),
        .set_data  (set_data),
        .sample    (sample),
        .out_data  (out_data),
        .out_sof   (out_sof),
        .out_eof   (out_eof),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow),
`ifdef RX_FRAMER_SEQ_EN
        .out_seq   (out_seq),
`endif
        .status    (status)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_reg(input int unsigned off, input logic [31:0] data);
        set_stb  = 1'b1;
        set_addr = 8'(B + off);
        set_data = data;
        tick();
        set_stb  = 1'b0;
    endtask

    function automatic logic [34:0] mk(input logic err, input logic sof, input logic eof,
                                       input logic [31:0] d);
        return {err, sof, eof, d};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        checks++;
        if (status !== 32'd0) begin errors++; $display("FAIL reset_status: got %h expected 0", status); end
        checks++;
        if (obs_w !== 35'd0 || overflow !== 1'b0) begin
            errors++; $display("FAIL reset_outputs: got %h ovf %b expected 0", obs_w, overflow);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_burst();
        exp_q.delete();
        set_reg(0, 32'd4);
        out_ready = 1'b1;
        set_reg(1, 32'h8000_000A);
        for (int k = 0; k < 16; k++) begin
            sample = ramp;
            // A second start mid-burst must be ignored.
            set_stb  = (k == 3);
            set_addr = 8'(B + 1);
            set_data = 32'h8000_0002;
            if (k < 10) exp_q.push_back(mk(1'b0, (k % 4 == 0), (k % 4 == 3) || (k == 9), ramp));
            if (k == 1) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== ramp - 32'd1) begin
                    errors++; $display("FAIL burst_latency: got v=%b %h expected v=1 %h", out_valid, out_data, ramp - 32'd1);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL burst_extra: got %h expected no word", obs_w);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (obs_w !== exp_w) begin errors++; $display("FAIL burst_word: got %h expected %h", obs_w, exp_w); end
                end
            end
            ramp++;
            tick();
        end
        set_stb = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL burst_missing: got %0d left expected 0", exp_q.size()); end
        checks++;
        if (status[30:29] !== 2'd0) begin errors++; $display("FAIL burst_idle: got %0d expected 0", status[30:29]); end
    endtask

    task automatic test_continuous();
        int pos;
        logic sof, eof;
        exp_q.delete();
        pos = 0;
        set_reg(0, 32'd3);
        out_ready = 1'b1;
        set_reg(1, 32'hC000_0000);
        for (int k = 0; k < 16; k++) begin
            sample   = ramp;
            set_stb  = (k == 5);
            set_addr = 8'(B + 1);
            set_data = 32'h2000_0000;
            if (k <= 6) begin
                sof = (pos == 0);
                eof = (pos == 2) || (k == 6);
                exp_q.push_back(mk(1'b0, sof, eof, ramp));
                pos = eof ? 0 : pos + 1;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL cont_extra: got %h expected no word", obs_w);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (obs_w !== exp_w) begin errors++; $display("FAIL cont_word: got %h expected %h", obs_w, exp_w); end
                end
            end
            ramp++;
            tick();
        end
        set_stb = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL cont_missing: got %0d left expected 0", exp_q.size()); end
        checks++;
        if (status[30:29] !== 2'd0) begin errors++; $display("FAIL cont_idle: got %0d expected 0", status[30:29]); end
    endtask

    task automatic test_len_zero();
        exp_q.delete();
        set_reg(0, 32'd0);
        out_ready = 1'b1;
        set_reg(1, 32'h8000_0003);
        for (int k = 0; k < 8; k++) begin
            sample = ramp;
            if (k < 3) exp_q.push_back(mk(1'b0, 1'b1, 1'b1, ramp));
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL len0_extra: got %h expected no word", obs_w);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (obs_w !== exp_w) begin errors++; $display("FAIL len0_word: got %h expected %h", obs_w, exp_w); end
                end
            end
            ramp++;
            tick();
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL len0_missing: got %0d left expected 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        logic        stalled;
        logic [34:0] held;
        exp_q.delete();
        stalled = 1'b0;
        held    = '0;
        set_reg(0, 32'd2);
        out_ready = 1'b0;
        set_reg(1, 32'h8000_0004);
        for (int k = 0; k < 20; k++) begin
            sample    = ramp;
            out_ready = (k % 2 == 1);
            if (k < 4) exp_q.push_back(mk(1'b0, (k % 2 == 0), (k % 2 == 1), ramp));
            if (stalled && out_valid) begin
                checks++;
                if (obs_w !== held) begin errors++; $display("FAIL bp_stable: got %h expected %h", obs_w, held); end
            end
            stalled = out_valid && !out_ready;
            held    = obs_w;
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL bp_extra: got %h expected no word", obs_w);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (obs_w !== exp_w) begin errors++; $display("FAIL bp_word: got %h expected %h", obs_w, exp_w); end
                end
            end
            ramp++;
            tick();
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL bp_missing: got %0d left expected 0", exp_q.size()); end
    endtask

    task automatic test_idle_cmds();
        out_ready = 1'b1;
        set_reg(1, 32'h8000_0000);
        tick();
        checks++;
        if (status[30:29] !== 2'd0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL idle_zero_burst: got st=%0d v=%b expected st=0 v=0", status[30:29], out_valid);
        end
        set_reg(1, 32'hA000_0005);
        tick();
        checks++;
        if (status[30:29] !== 2'd0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL idle_start_stop: got st=%0d v=%b expected st=0 v=0", status[30:29], out_valid);
        end
        set_reg(1, 32'h2000_0000);
        checks++;
        if (status[30:29] !== 2'd0) begin errors++; $display("FAIL idle_stop: got st=%0d expected 0", status[30:29]); end
    endtask

    task automatic test_overflow();
        exp_q.delete();
        set_reg(0, 32'd8);
        out_ready = 1'b0;
        set_reg(1, 32'hC000_0000);
        for (int k = 0; k < 20; k++) begin
            sample    = ramp;
            out_ready = (k >= 8);
            if (k < 4) exp_q.push_back(mk(1'b0, (k == 0), 1'b0, ramp));
            if (k == 5) begin
                checks++;
                if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
                checks++;
                if (status[30:29] !== 2'd2) begin errors++; $display("FAIL ovf_state: got %0d expected 2", status[30:29]); end
            end
            if (k == 8) exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 32'd0));
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL ovf_extra: got %h expected no word", obs_w);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (obs_w !== exp_w) begin errors++; $display("FAIL ovf_word: got %h expected %h", obs_w, exp_w); end
                end
            end
            ramp++;
            tick();
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL ovf_missing: got %0d left expected 0", exp_q.size()); end
        checks++;
        if (overflow !== 1'b1 || status[30:29] !== 2'd0) begin
            errors++; $display("FAIL ovf_sticky: got ovf=%b st=%0d expected ovf=1 st=0", overflow, status[30:29]);
        end
        set_reg(2, 32'd0);
        checks++;
        if (overflow !== 1'b0 || status[31] !== 1'b0) begin
            errors++; $display("FAIL ovf_clear: got %b expected 0", overflow);
        end
    endtask

    task automatic test_reset_mid();
        exp_q.delete();
        set_reg(0, 32'd4);
        out_ready = 1'b0;
        set_reg(1, 32'h8000_0014);
        for (int k = 0; k < 3; k++) begin
            sample = ramp;
            ramp++;
            tick();
        end
        rst = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", out_valid); end
        checks++;
        if (status !== 32'd0) begin errors++; $display("FAIL midrst_status: got %h expected 0", status); end
        rst = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            sample = ramp;
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_residual: got %h expected no word", obs_w); end
            ramp++;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_burst();
        test_continuous();
        test_len_zero();
        test_back_to_back();
        test_idle_cmds();
        test_overflow();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
